mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the ARM processor core. Each cycle it drives the shared-ALU, shared-memory datapath from a state machine that steps every instruction through fetch, decode, execute, memory and writeback. It holds the architectural NZCV flags, evaluates each instruction's condition field, and gates all architectural writes. It takes instr[31:20] from the instruction register and the datapath ALU flags, and it replaces the single-cycle controller when the core is built in multicycle form.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = in reset).
- cond  in  4  instr[31:28].
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20] (I, cmd[3:0], S/L).
- aluflags  in  4  datapath ALU {N,Z,C,V}, valid in the current cycle.
- pcwrite  out  1  PC load enable.
- irwrite  out  1  instruction register load enable.
- memwrite  out  1  data memory write enable.
- regwrite  out  1  register file write enable.
- adrsrc  out  1  memory address select (0 = PC, 1 = ALU result register).
- alusrca  out  1  ALU A select (0 = register A, 1 = PC).
- alusrcb  out  2  ALU B select (00 = register B, 01 = extended immediate, 10 = constant 4).
- resultsrc  out  2  result select (00 = ALU out register, 01 = data register, 10 = ALU result).
- immsrc  out  2  immediate extend select.
- regsrc  out  2  register-read address selects.
- alucontrol  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- state  out  4  current FSM state, for debug and verification.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 go to FETCH on the next edge.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: adrsrc=0, irwrite=1, alusrca=1, alusrcb=10, resultsrc=10, ADD, nextpc=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alusrca=1, alusrcb=10, resultsrc=10, ADD.
  - Next state by op: op=01 → MEMADR; op=00 with funct[5]=0 → EXECR; op=00 with funct[5]=1 → EXECI; op=10 → BRANCH; op=11 → UNKNOWN.
- MEMADR:
  - Outputs: alusrca=0, alusrcb=01, ADD.
  - Next state: MEMRD if funct[0]=1, else MEMWR.
- MEMRD: adrsrc=1, resultsrc=00. Next state: MEMWB.
- MEMWB: resultsrc=01, regw=1. Next state: FETCH.
- MEMWR: adrsrc=1, resultsrc=00, memw=1. Next state: FETCH.
- EXECR: alusrca=0, alusrcb=00, aluop=1. Next state: ALUWB.
- EXECI: alusrca=0, alusrcb=01, aluop=1. Next state: ALUWB.
- ALUWB: resultsrc=00, regw=1. Next state: FETCH.
- BRANCH:
  - Outputs: alusrca=0, alusrcb=01, resultsrc=10, ADD, branch=1.
  - Next state: FETCH.
- UNKNOWN: no writes. Next state: FETCH.
- ALU decode when aluop=1, by funct[4:1]:
  - 0100 → ADD (00); 0010 → SUB (01); 0000 → AND (10); 1100 → ORR (11).
  - Any other cmd → 00 with flagw=00.
  - flagw[1] (NZ) = funct[0].
  - flagw[0] (CV) = funct[0] & (ADD or SUB).
- When aluop=0: alucontrol=00 and flagw=00.
- immsrc = op, combinational. regsrc[0] = (op==10). regsrc[1] = (op==01).
- Condition evaluation:
  - condex is combinational, from cond and the stored flags.
  - Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL(1110) 1; 1111 → 0.
- Flag register update:
  - NZ loads aluflags[3:2] when flagw[1]&condex.
  - CV loads aluflags[1:0] when flagw[0]&condex.
  - Loads occur only in EXECR/EXECI.
- Gated outputs:
  - regwrite = regw & condex.
  - memwrite = memw & condex.
  - pcwrite = nextpc | (branch & condex).
- A failed condition still walks the full state sequence, with no register, memory, flag or branch write.

## Timing
- Reset low:
  - state=FETCH and flags=0000, immediately (asynchronous).
  - pcwrite, irwrite, regwrite and memwrite are forced to 0 while reset is low.
  - Other outputs show FETCH values.
- The first rising edge after reset goes high completes FETCH.
- Cycles per instruction: LDR 5; STR 4; data-processing 4; B 3; op=11 3. No stalls.
- All control outputs are Moore (from state) except:
  - the condex-gated enables, which respond combinationally to cond and flags;
  - alucontrol, immsrc and regsrc, which respond combinationally to funct and op.
- Flags written in an EXEC state take effect from the ALUWB cycle. The same instruction's ALUWB regwrite therefore uses the pre-update flags for condex. The flag register must hold the old value until the EXEC edge and the condex term for ALUWB must be registered, or use an equivalent so that ALUWB gating matches EXEC-cycle condex.
- Reset falling mid-instruction aborts the instruction with no partial write. The core restarts at FETCH.

## Test plan
- Reset low for 3 cycles, then high:
  - state=0 and all write enables 0 during reset.
  - state sequence 0,1 begins on the following edges.
- ADD R1,R1,R2 (0xE0811002):
  - states 0,1,6,8.
  - alucontrol=00 in state 6.
  - regwrite=1 only in state 8.
  - flags unchanged.
- SUBS R3,R1,R1 (0xE0513001) with aluflags=0110 in state 6:
  - flags become 0110.
  - A following ADDNE (cond 0001) reaches ALUWB with regwrite=0.
- LDR R2,[R1,#4] (0xE5912004):
  - states 0,1,2,3,4.
  - adrsrc=1 in state 3; resultsrc=01 and regwrite=1 in state 4.
- STR followed by BEQ (0x0A000002):
  - STR memwrite=1 only in state 5.
  - BEQ with Z=1: pcwrite=1 in state 9. With Z=0: pcwrite=0 in state 9.
- Reset low during state 5 of a store:
  - memwrite drops to 0 immediately.
  - state=0 and flags=0000.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags and gates every architectural write on the condition field.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] aluflags,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc,
  output logic [1:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    UNKNOWN = 4'd10
  } state_t;

  typedef struct packed {
    logic       adrsrc;
    logic       irw;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

  state_t     cur, nxt;
  ctrl_t      ctl;
  logic [3:0] flags;
  logic [1:0] flagw;
  logic       condex, condexd, wrcond, inexec;
  logic       n, z, c, v;

  // Moore control word for a given state; registered alongside the state itself
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t w;
    w = '0;
    case (s)
      FETCH: begin
        w.irw = 1'b1; w.alusrca = 1'b1; w.alusrcb = 2'b10;
        w.resultsrc = 2'b10; w.nextpc = 1'b1;
      end
      DECODE: begin
        w.alusrca = 1'b1; w.alusrcb = 2'b10; w.resultsrc = 2'b10;
      end
      MEMADR:  w.alusrcb = 2'b01;
      MEMRD:   w.adrsrc = 1'b1;
      MEMWB:   begin w.resultsrc = 2'b01; w.regw = 1'b1; end
      MEMWR:   begin w.adrsrc = 1'b1; w.memw = 1'b1; end
      EXECR:   w.aluop = 1'b1;
      EXECI:   begin w.alusrcb = 2'b01; w.aluop = 1'b1; end
      ALUWB:   w.regw = 1'b1;
      BRANCH:  begin w.alusrcb = 2'b01; w.resultsrc = 2'b10; w.branch = 1'b1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (op)
          2'b00:   nxt = funct[5] ? EXECI : EXECR;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = UNKNOWN;
        endcase
      end
      MEMADR:  nxt = funct[0] ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      EXECR:   nxt = ALUWB;
      EXECI:   nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= FETCH;
      ctl <= decode_state(FETCH);
    end else begin
      cur <= nxt;
      ctl <= decode_state(nxt);
    end
  end

  always_comb begin
    alucontrol = 2'b00;
    flagw      = 2'b00;
    if (ctl.aluop) begin
      case (funct[4:1])
        4'b0100: begin alucontrol = 2'b00; flagw = {funct[0], funct[0]}; end
        4'b0010: begin alucontrol = 2'b01; flagw = {funct[0], funct[0]}; end
        4'b0000: begin alucontrol = 2'b10; flagw = {funct[0], 1'b0}; end
        4'b1100: begin alucontrol = 2'b11; flagw = {funct[0], 1'b0}; end
        default: begin alucontrol = 2'b00; flagw = 2'b00; end
      endcase
    end
  end

  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  assign inexec = (cur == EXECR) || (cur == EXECI);

  // ALUWB must be gated by the condition seen in EXEC, before that edge's flag update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags   <= 4'b0000;
      condexd <= 1'b0;
    end else if (inexec) begin
      condexd <= condex;
      if (flagw[1] & condex) flags[3:2] <= aluflags[3:2];
      if (flagw[0] & condex) flags[1:0] <= aluflags[1:0];
    end
  end

  assign wrcond    = (cur == ALUWB) ? condexd : condex;
  assign regwrite  = ctl.regw & wrcond & reset;
  assign memwrite  = ctl.memw & condex & reset;
  assign pcwrite   = (ctl.nextpc | (ctl.branch & condex)) & reset;
  assign irwrite   = ctl.irw & reset;
  assign adrsrc    = ctl.adrsrc;
  assign alusrca   = ctl.alusrca;
  assign alusrcb   = ctl.alusrcb;
  assign resultsrc = ctl.resultsrc;
  assign immsrc    = op;
  assign regsrc    = {op == 2'b01, op == 2'b10};
  assign state     = cur;

endmodule
